icap_readback_controller: RTL and testbench

- Reads configuration frame data back out of the ICAP port. It is the read-direction counterpart of the bitstream write path.
- On `start` it performs three phases on the ICAP interface:
  - writes the readback command preamble (sync, RCFG, FAR, FDRO read header);
  - reads `word_count` 32-bit words;
  - writes a DESYNC postamble.
- Captured words are buffered and delivered as an MSB-first byte stream with a valid/ready handshake.
- The ICAPE2 primitive is instantiated by the top-level wrapper; this block drives and receives its pins as plain ports.

---
 rtl/icap_readback_controller.sv | 236 +++++++++++++++++++++++
 tb/tb_icap_readback_controller.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icap_readback_controller.sv
// rtl/icap_readback_controller.sv - ICAP configuration readback sequencer with MSB-first byte stream output
module icap_readback_controller #(
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int READ_LAT   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      frame_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic             icap_csib,
  output logic             icap_rdwrb,
  output logic [31:0]      icap_i,
  input  logic [31:0]      icap_o,
  input  logic             icap_busy,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             readback_busy,
  output logic             readback_done
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FC_W   = PTR_W + 1;
  localparam int FCX_W  = FC_W + 1;
  localparam int SUM_W  = CNT_W + 1;
  localparam logic [FC_W:0] DEPTH_V = FCX_W'(FIFO_DEPTH);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE,
    S_SW_RD1,
    S_SW_RD2,
    S_READ,
    S_DRAIN,
    S_SW_WR1,
    S_SW_WR2,
    S_POST,
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [3:0]          step;
  logic [31:0]         far_q;
  logic [CNT_W-1:0]    wc_q;
  logic [CNT_W-1:0]    captured;
  logic [FC_W-1:0]     inflight, inflight_nxt;
  logic [FC_W-1:0]     fifo_cnt, fifo_cnt_nxt;
  logic [READ_LAT-1:0] strobe_dly;
  logic [31:0]         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [1:0]          byte_idx;
  logic [31:0]         pre_word, post_word, head_word;

  logic [SUM_W-1:0]    req_total, wc_ext;
  logic [FC_W:0]       credit_used;
  logic                strobe, emerge, capture, byte_fire, pop, start_ok;

  // Words requested so far (stored or still in the latency pipe) and FIFO slots reserved.
  assign req_total   = {1'b0, captured} + SUM_W'(inflight);
  assign wc_ext      = {1'b0, wc_q};
  assign credit_used = {1'b0, fifo_cnt} + {1'b0, inflight};

  // A read strobe is issued only when the word is still needed and a FIFO slot is reserved for it.
  assign strobe    = (state == S_READ) && (req_total < wc_ext) && (credit_used < DEPTH_V);
  assign emerge    = strobe_dly[READ_LAT-1];
  assign capture   = emerge && !icap_busy;
  assign byte_fire = rd_valid && rd_ready;
  assign pop       = byte_fire && (byte_idx == 2'd3);
  assign start_ok  = start && (state == S_IDLE) && (fifo_cnt == '0);

  assign readback_busy = (state != S_IDLE);
  assign readback_done = (state == S_DONE);
  assign head_word     = fifo_mem[rd_ptr];

  // Preamble and postamble command word tables, indexed by the per-state step counter.
  always_comb begin
    pre_word  = 32'h0000_0000;
    post_word = 32'h0000_0000;
    case (step)
      4'd0:    pre_word = 32'hFFFF_FFFF;
      4'd1:    pre_word = 32'hAA99_5566;
      4'd2:    pre_word = 32'h2000_0000;
      4'd3:    pre_word = 32'h3000_8001;
      4'd4:    pre_word = 32'h0000_0004;
      4'd5:    pre_word = 32'h3000_2001;
      4'd6:    pre_word = far_q;
      4'd7:    pre_word = 32'h2800_6000;
      4'd8:    pre_word = {5'b01001, 27'(wc_q)};
      4'd9:    pre_word = 32'h2000_0000;
      4'd10:   pre_word = 32'h2000_0000;
      default: pre_word = 32'h0000_0000;
    endcase
    case (step[1:0])
      2'd0:    post_word = 32'h3000_8001;
      2'd1:    post_word = 32'h0000_000D;
      default: post_word = 32'h2000_0000;
    endcase
  end

  // Next-state logic and ICAP pin drive.
  always_comb begin
    state_nxt  = state;
    icap_csib  = 1'b1;
    icap_rdwrb = 1'b0;
    icap_i     = 32'h0000_0000;
    case (state)
      S_IDLE: begin
        if (start_ok) state_nxt = S_PRE;
      end
      S_PRE: begin
        icap_csib = 1'b0;
        icap_i    = pre_word;
        if (step == 4'd10) state_nxt = S_SW_RD1;
      end
      S_SW_RD1: begin
        state_nxt = S_SW_RD2;
      end
      S_SW_RD2: begin
        icap_rdwrb = 1'b1;
        state_nxt  = (wc_q == '0) ? S_SW_WR1 : S_READ;
      end
      S_READ: begin
        icap_rdwrb = 1'b1;
        icap_csib  = !strobe;
        if (req_total == wc_ext) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        icap_rdwrb = 1'b1;
        if (req_total < wc_ext) state_nxt = S_READ;
        else if (inflight == '0) state_nxt = S_SW_WR1;
      end
      S_SW_WR1: begin
        icap_rdwrb = 1'b1;
        state_nxt  = S_SW_WR2;
      end
      S_SW_WR2: begin
        state_nxt = S_POST;
      end
      S_POST: begin
        icap_csib = 1'b0;
        icap_i    = post_word;
        if (step == 4'd3) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobe and FIFO occupancy bookkeeping for the next cycle.
  always_comb begin
    inflight_nxt = inflight;
    fifo_cnt_nxt = fifo_cnt;
    case ({strobe, emerge})
      2'b10:   inflight_nxt = inflight + FC_W'(1);
      2'b01:   inflight_nxt = inflight - FC_W'(1);
      default: inflight_nxt = inflight;
    endcase
    case ({capture, pop})
      2'b10:   fifo_cnt_nxt = fifo_cnt + FC_W'(1);
      2'b01:   fifo_cnt_nxt = fifo_cnt - FC_W'(1);
      default: fifo_cnt_nxt = fifo_cnt;
    endcase
  end

  // State register and per-state step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      step  <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) step <= 4'd0;
      else                    step <= step + 4'd1;
    end
  end

  // Operation parameters, word counters and the read-latency delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      far_q      <= 32'h0000_0000;
      wc_q       <= '0;
      captured   <= '0;
      inflight   <= '0;
      strobe_dly <= '0;
    end else begin
      if (start_ok) begin
        far_q    <= frame_addr;
        wc_q     <= word_count;
        captured <= '0;
      end else if (capture) begin
        captured <= captured + CNT_W'(1);
      end
      inflight   <= inflight_nxt;
      strobe_dly <= (strobe_dly << 1) | READ_LAT'(strobe);
    end
  end

  // Captured-word FIFO and byte serializer; the head word stays in the FIFO until its last byte is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= 32'h0000_0000;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      byte_idx <= 2'd0;
      rd_valid <= 1'b0;
    end else begin
      if (capture) begin
        fifo_mem[wr_ptr] <= icap_o;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (byte_fire) byte_idx <= byte_idx + 2'd1;
      fifo_cnt <= fifo_cnt_nxt;
      rd_valid <= (fifo_cnt_nxt != '0);
    end
  end

  // Byte select from the FIFO head, MSB first.
  always_comb begin
    rd_data = 8'h00;
    if (rd_valid) begin
      case (byte_idx)
        2'd0:    rd_data = head_word[31:24];
        2'd1:    rd_data = head_word[23:16];
        2'd2:    rd_data = head_word[15:8];
        default: rd_data = head_word[7:0];
      endcase
    end
  end

endmodule

// File: tb/tb_icap_readback_controller.sv
// tb/tb_icap_readback_controller.sv - self-checking bench for icap_readback_controller
module tb_icap_readback_controller;

  localparam int CNT_W = 16;
  localparam int DEPTH = 8;
  localparam int RL    = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [31:0]      frame_addr;
  logic [CNT_W-1:0] word_count;
  logic             icap_csib;
  logic             icap_rdwrb;
  logic [31:0]      icap_i;
  logic [31:0]      icap_o;
  logic             icap_busy;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic             readback_busy;
  logic             readback_done;

  icap_readback_controller #(.CNT_W(CNT_W), .FIFO_DEPTH(DEPTH), .READ_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_addr(frame_addr), .word_count(word_count),
    .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb), .icap_i(icap_i), .icap_o(icap_o),
    .icap_busy(icap_busy), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .readback_busy(readback_busy), .readback_done(readback_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0]      exp_far;
  logic [CNT_W-1:0] exp_wc;
  logic [63:0]      busy_mask;
  int               pend[$];
  int               strobe_cnt, slot_cnt, cap_cnt, byte_cnt, wr_cnt, done_cnt, toggle_cnt;
  int               first_v, cap_cyc;
  logic             hold_v, prev_rdwrb, prev_csib, prev_done;
  logic [7:0]       hold_d;
  logic [31:0]      wr_log [16];
  logic [7:0]       byte_log [128];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_for(input int k);
    logic [7:0] b;
    b = 8'(4 * k);
    if (k == 0) return 32'h1122_3344;
    if (k == 1) return 32'h5566_7788;
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  function automatic logic [7:0] exp_byte(input int j);
    logic [31:0] w;
    w = word_for(j / 4);
    return 8'(w >> (8 * (3 - (j % 4))));
  endfunction

  function automatic logic [31:0] exp_wr(input int i);
    case (i)
      0:       return 32'hFFFF_FFFF;
      1:       return 32'hAA99_5566;
      2:       return 32'h2000_0000;
      3:       return 32'h3000_8001;
      4:       return 32'h0000_0004;
      5:       return 32'h3000_2001;
      6:       return exp_far;
      7:       return 32'h2800_6000;
      8:       return 32'h4800_0000 | 32'(exp_wc);
      9, 10:   return 32'h2000_0000;
      11:      return 32'h3000_8001;
      12:      return 32'h0000_000D;
      default: return 32'h2000_0000;
    endcase
  endfunction

  task automatic arm(input logic [31:0] far, input logic [CNT_W-1:0] wc, input logic [63:0] mask);
    exp_far = far; exp_wc = wc; busy_mask = mask;
    frame_addr = far; word_count = wc;
    pend.delete();
    strobe_cnt = 0; slot_cnt = 0; cap_cnt = 0; byte_cnt = 0; wr_cnt = 0;
    done_cnt = 0; toggle_cnt = 0; first_v = -1; cap_cyc = -1;
    hold_v = 1'b0; prev_rdwrb = icap_rdwrb; prev_csib = 1'b1; prev_done = 1'b0;
  endtask

  // Per-cycle model: ICAP responder plus comparison of every meaningful DUT output.
  task automatic monitor();
    icap_busy = 1'b1;
    icap_o    = 32'hDEAD_0000 ^ 32'(cyc);
    if (pend.size() > 0 && pend[0] + RL == cyc) begin
      void'(pend.pop_front());
      if (!(slot_cnt < 64 && busy_mask[slot_cnt])) begin
        icap_busy = 1'b0;
        icap_o    = word_for(cap_cnt);
        if (cap_cnt == 0) cap_cyc = cyc;
        cap_cnt++;
      end
      slot_cnt++;
    end
    if (!icap_csib && icap_rdwrb) begin
      pend.push_back(cyc);
      strobe_cnt++;
    end
    if (!icap_csib && !icap_rdwrb) begin
      if (wr_cnt < 15) begin
        wr_log[wr_cnt] = icap_i;
        check($sformatf("icap_wr[%0d]", wr_cnt), icap_i, exp_wr(wr_cnt));
      end else begin
        check("icap_wr_extra", 32'(wr_cnt), 32'd14);
      end
      wr_cnt++;
    end
    if (icap_rdwrb !== prev_rdwrb) begin
      toggle_cnt++;
      check("rdwrb_toggle_csib", {30'd0, prev_csib, icap_csib}, 32'd3);
    end
    if (hold_v) begin
      check("rd_hold_valid", 32'(rd_valid), 32'd1);
      check("rd_hold_data", 32'(rd_data), 32'(hold_d));
    end
    if (rd_valid && first_v < 0) first_v = cyc;
    if (rd_valid && rd_ready) begin
      if (byte_cnt < 128) byte_log[byte_cnt] = rd_data;
      check($sformatf("rd_byte[%0d]", byte_cnt), 32'(rd_data), 32'(exp_byte(byte_cnt)));
      byte_cnt++;
    end
    if (readback_done) begin
      done_cnt++;
      check("busy_at_done", 32'(readback_busy), 32'd1);
    end
    if (prev_done) check("busy_after_done", 32'(readback_busy), 32'd0);
    check("fifo_bound", 32'(dut.fifo_cnt <= DEPTH), 32'd1);
    hold_v     = rd_valid && !rd_ready;
    hold_d     = rd_data;
    prev_rdwrb = icap_rdwrb;
    prev_csib  = icap_csib;
    prev_done  = readback_done;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    int n = 0;
    while (done_cnt == 0 && n < limit) begin tick(); n++; end
    check({name, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
  endtask

  task automatic wait_bytes(input int nb, input int limit, input string name);
    int n = 0;
    while (byte_cnt < nb && n < limit) begin tick(); n++; end
    check({name, "_bytes"}, 32'(byte_cnt), 32'(nb));
  endtask

  task automatic end_checks(input int wc, input int exp_strb, input string name);
    check({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({name, "_wr_cnt"}, 32'(wr_cnt), 32'd15);
    check({name, "_strobes"}, 32'(strobe_cnt), 32'(exp_strb));
    check({name, "_captured"}, 32'(cap_cnt), 32'(wc));
    check({name, "_valid_low"}, 32'(rd_valid), 32'd0);
    if (wc != 0) check({name, "_first_lat"}, 32'(first_v), 32'(cap_cyc + 1));
  endtask

  task automatic run_full(input logic [31:0] far, input logic [CNT_W-1:0] wc, input logic [63:0] mask,
                          input int exp_strb, input bit restart, input string name);
    arm(far, wc, mask);
    rd_ready = 1'b1;
    pulse_start();
    if (restart) begin
      repeat (12) tick();
      check({name, "_busy_before_restart"}, 32'(readback_busy), 32'd1);
      pulse_start();
    end
    wait_done(4000, name);
    tick();
    wait_bytes(4 * int'(wc), 4000, name);
    tick();
    end_checks(int'(wc), exp_strb, name);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; rd_ready = 1'b0;
    icap_o = 32'h0; icap_busy = 1'b1;
    frame_addr = 32'h0; word_count = '0;
    arm(32'h0, '0, 64'h0);
    repeat (3) tick();
    check("rst_csib", 32'(icap_csib), 32'd1);
    check("rst_rdwrb", 32'(icap_rdwrb), 32'd0);
    check("rst_icap_i", icap_i, 32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_busy", 32'(readback_busy), 32'd0);
    check("rst_done", 32'(readback_done), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic two-word readback.
    run_full(32'h0040_0100, 16'd2, 64'h0, 2, 1'b0, "t1");
    check("t1_pin_far", wr_log[6], 32'h0040_0100);
    check("t1_pin_fdro", wr_log[8], 32'h4800_0002);
    check("t1_pin_desync", wr_log[12], 32'h0000_000D);
    check("t1_pin_b0", 32'(byte_log[0]), 32'h11);
    check("t1_pin_b3", 32'(byte_log[3]), 32'h44);
    check("t1_pin_b7", 32'(byte_log[7]), 32'h88);

    // Zero-length readback.
    run_full(32'h0000_0300, 16'd0, 64'h0, 0, 1'b0, "t2");
    check("t2_toggles", 32'(toggle_cnt), 32'd2);
    check("t2_pin_fdro", wr_log[8], 32'h4800_0000);

    // Backpressure: FIFO fills, strobes stall, then drain.
    arm(32'h0000_0200, 16'd20, 64'h0);
    rd_ready = 1'b0;
    pulse_start();
    repeat (100) tick();
    check("t3_captured_at_stall", 32'(cap_cnt), 32'd8);
    check("t3_strobes_at_stall", 32'(strobe_cnt), 32'd8);
    check("t3_busy_at_stall", 32'(readback_busy), 32'd1);
    rd_ready = 1'b1;
    wait_done(4000, "t3");
    tick();
    wait_bytes(80, 4000, "t3");
    tick();
    end_checks(20, 20, "t3");
    check("t3_pin_b8", 32'(byte_log[8]), 32'h08);
    check("t3_pin_b79", 32'(byte_log[79]), 32'h4F);

    // Busy on 3rd and 4th read slots; a start while busy must be ignored.
    run_full(32'h0000_0400, 16'd5, 64'h0C, 7, 1'b1, "t4");
    check("t4_pin_b8", 32'(byte_log[8]), 32'h08);

    // Start while FIFO still holds data must be ignored.
    arm(32'h0000_0500, 16'd1, 64'h0);
    rd_ready = 1'b0;
    pulse_start();
    wait_done(500, "t6");
    tick();
    check("t6_valid_pending", 32'(rd_valid), 32'd1);
    pulse_start();
    repeat (20) tick();
    check("t6_busy_ignored", 32'(readback_busy), 32'd0);
    check("t6_no_new_writes", 32'(wr_cnt), 32'd15);
    check("t6_no_new_strobes", 32'(strobe_cnt), 32'd1);
    rd_ready = 1'b1;
    wait_bytes(4, 100, "t6");
    tick();
    check("t6_valid_low", 32'(rd_valid), 32'd0);

    // Asynchronous reset during READ, then a clean run.
    arm(32'h0040_0100, 16'd20, 64'h0);
    rd_ready = 1'b1;
    pulse_start();
    n = 0;
    while (strobe_cnt < 3 && n < 200) begin tick(); n++; end
    check("t5_reached_read", 32'(strobe_cnt >= 3), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_csib", 32'(icap_csib), 32'd1);
    check("t5_rst_rdwrb", 32'(icap_rdwrb), 32'd0);
    check("t5_rst_icap_i", icap_i, 32'h0);
    check("t5_rst_rd_valid", 32'(rd_valid), 32'd0);
    check("t5_rst_rd_data", 32'(rd_data), 32'd0);
    check("t5_rst_busy", 32'(readback_busy), 32'd0);
    check("t5_rst_done", 32'(readback_done), 32'd0);
    arm(32'h0123_4567, 16'd3, 64'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_full(32'h0123_4567, 16'd3, 64'h0, 3, 1'b0, "t5");
    check("t5_pin_sync0", wr_log[0], 32'hFFFF_FFFF);
    check("t5_pin_far", wr_log[6], 32'h0123_4567);
    check("t5_pin_fdro", wr_log[8], 32'h4800_0003);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
